// File: rtl/calc_display_driver.sv
// Captures an 8-bit result, converts it to BCD by sequential double-dabble and scans it onto a 3-digit 7-segment display.
// Optional leading-zero blanking: define CALC_DISP_LZB_EN.
module calc_display_driver #(
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] digit_en
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_shift;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic        r_pend;
  logic [7:0]  r_pend_val;
  logic [3:0]  r_hun, r_ten, r_one;
  logic [15:0] r_div;
  logic [2:0]  r_de;
  logic [6:0]  r_seg;

  logic [11:0] w_adj;
  logic        w_wrap;
  logic [2:0]  w_de_nxt;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_hun      <= '0;
      r_ten      <= '0;
      r_one      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_shift} <= {w_adj[10:0], r_shift, 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= S_UPDATE;
          if (load) begin
            r_pend     <= 1'b1;
            r_pend_val <= value;
          end
        end
        S_UPDATE: begin
          r_hun <= r_bcd[11:8];
          r_ten <= r_bcd[7:4];
          r_one <= r_bcd[3:0];
          r_pend <= 1'b0;
          // A load arriving in this cycle supersedes the stored pending value.
          if (load || r_pend) begin
            r_shift <= load ? value : r_pend_val;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wrap   = (r_div == DIV_LAST);
    w_de_nxt = w_wrap ? {r_de[1:0], r_de[2]} : r_de;
    w_blank  = 1'b0;
    case (w_de_nxt)
      3'b010: begin
        w_nib = r_ten;
`ifdef CALC_DISP_LZB_EN
        w_blank = (r_hun == 4'd0) && (r_ten == 4'd0);
`endif
      end
      3'b100: begin
        w_nib = r_hun;
`ifdef CALC_DISP_LZB_EN
        w_blank = (r_hun == 4'd0);
`endif
      end
      default: w_nib = r_one;
    endcase
    w_seg_nxt = w_blank ? 7'h00 : seg_decode(w_nib);
  end

  // seg is decoded for the digit being enabled on the same edge.
  always_ff @(posedge clock) begin
    if (Reset) begin
      r_div <= '0;
      r_de  <= 3'b001;
      r_seg <= 7'h3F;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 16'd1;
      r_de  <= w_de_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign seg      = r_seg;
  assign digit_en = r_de;

endmodule

// File: tb/tb_calc_display_driver.sv
// Self-checking bench for calc_display_driver: vector table, corner sequences and randomized run against a value-level model.
module tb_calc_display_driver;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] value = '0;
  logic       load  = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [2:0] digit_en;

  calc_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clock(clock), .Reset(Reset), .value(value), .load(load),
    .busy(busy), .seg(seg), .digit_en(digit_en)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: display value as an integer, conversion as a countdown to its update edge
  int m_disp  = 0;
  int m_cur   = 0;
  int m_left  = 0;
  int m_busy  = 0;
  int m_pv    = 0;
  int m_pval  = 0;
  int m_s     = 0;
  int m_idx   = 0;
  logic [6:0] m_seg = 7'h3F;

  localparam logic [6:0] SEG_LUT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] exp_seg(input int d, input int idx);
    int dig;
    logic blank;
    blank = 1'b0;
    dig = (idx == 0) ? d % 10 : (idx == 1) ? (d / 10) % 10 : d / 100;
`ifdef CALC_DISP_LZB_EN
    if (idx == 2 && d < 100) blank = 1'b1;
    if (idx == 1 && d < 10)  blank = 1'b1;
`endif
    return blank ? 7'h00 : SEG_LUT[dig];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ld, input logic [7:0] v, input logic rst);
    int old_disp;
    load = ld; value = v; Reset = rst;
    @(posedge clock);
    old_disp = m_disp;
    if (rst) begin
      m_busy = 0; m_pv = 0; m_disp = 0; m_s = 0;
    end else begin
      if (m_busy != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_cur;
          if (ld) begin m_cur = v; m_left = 9; end
          else if (m_pv != 0) begin m_cur = m_pval; m_left = 9; end
          else m_busy = 0;
          m_pv = 0;
        end else if (ld) begin
          m_pv = 1; m_pval = v;
        end
      end else if (ld) begin
        m_busy = 1; m_cur = v; m_left = 9;
      end
      m_s++;
    end
    m_idx = (m_s / DIV) % 3;
    m_seg = rst ? 7'h3F : exp_seg(old_disp, m_idx);
    #1;
    chk("busy", busy, m_busy);
    chk("digit_en", digit_en, 3'b001 << m_idx);
    chk("seg", seg, m_seg);
    load = 1'b0; Reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] v;
    logic [6:0] s_one;
    logic [6:0] s_ten;
    logic [6:0] s_hun;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int bc;
`ifdef CALC_DISP_LZB_EN
    tbl[0] = '{8'd255, 7'h6D, 7'h6D, 7'h5B};
    tbl[1] = '{8'd7,   7'h07, 7'h00, 7'h00};
    tbl[2] = '{8'd0,   7'h3F, 7'h00, 7'h00};
    tbl[3] = '{8'd100, 7'h3F, 7'h3F, 7'h06};
    tbl[4] = '{8'd42,  7'h5B, 7'h66, 7'h00};
    tbl[5] = '{8'd9,   7'h6F, 7'h00, 7'h00};
    tbl[6] = '{8'd180, 7'h3F, 7'h7F, 7'h06};
    tbl[7] = '{8'd205, 7'h6D, 7'h3F, 7'h5B};
`else
    tbl[0] = '{8'd255, 7'h6D, 7'h6D, 7'h5B};
    tbl[1] = '{8'd7,   7'h07, 7'h3F, 7'h3F};
    tbl[2] = '{8'd0,   7'h3F, 7'h3F, 7'h3F};
    tbl[3] = '{8'd100, 7'h3F, 7'h3F, 7'h06};
    tbl[4] = '{8'd42,  7'h5B, 7'h66, 7'h3F};
    tbl[5] = '{8'd9,   7'h6F, 7'h3F, 7'h3F};
    tbl[6] = '{8'd180, 7'h3F, 7'h7F, 7'h06};
    tbl[7] = '{8'd205, 7'h6D, 7'h3F, 7'h5B};
`endif

    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_digit_en", digit_en, 3'b001);
    chk("rst_seg", seg, 7'h3F);

    // Vector table: busy length, then one full frame of digits
    for (int i = 0; i < 8; i++) begin
      bc = 0;
      step(1'b1, tbl[i].v, 1'b0);
      if (busy) bc++;
      for (int c = 0; c < 9; c++) begin
        step(1'b0, 8'd0, 1'b0);
        if (busy) bc++;
      end
      chk("busy_len", bc, 9);
      for (int c = 0; c < 3 * DIV; c++) begin
        step(1'b0, 8'd0, 1'b0);
        case (m_idx)
          0:       chk("tbl_ones", seg, tbl[i].s_one);
          1:       chk("tbl_tens", seg, tbl[i].s_ten);
          default: chk("tbl_hund", seg, tbl[i].s_hun);
        endcase
      end
    end

    // Pending: 100, then 42 and 9 while busy; 9 overwrites 42
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd100, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd42, 1'b0);
    step(1'b1, 8'd9, 1'b0);
    for (int c = 5; c < 18; c++) begin
      step(1'b0, 8'd0, 1'b0);
      chk("pend_busy_hold", busy, 1);
      if (c == 9) chk("pend_first", m_disp, 100);
    end
    step(1'b0, 8'd0, 1'b0);
    chk("pend_idle", busy, 0);
    chk("pend_second", m_disp, 9);
    for (int c = 0; c < 2 * DIV; c++) step(1'b0, 8'd0, 1'b0);

    // Reset in the 4th SHIFT cycle aborts the conversion
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd200, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    for (int c = 0; c < 15; c++) begin
      step(1'b0, 8'd0, 1'b0);
      chk("abort_busy", busy, 0);
    end

    // Load together with reset is dropped
    step(1'b1, 8'd55, 1'b1);
    chk("ldrst_busy", busy, 0);
    for (int c = 0; c < 12; c++) step(1'b0, 8'd0, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
